// File: rtl/matrix_scan_ctrl_if.sv
// Framebuffer read port plus HUB75 panel pins, shared by the scan controller and its environment.
// master = controller side, slave = RAM/panel side.
interface matrix_scan_ctrl_if;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic        r1;
  logic        g1;
  logic        b1;
  logic        r2;
  logic        g2;
  logic        b2;
  logic        hub_clk;
  logic        hub_lat;
  logic        hub_oe_n;
  logic [3:0]  row_addr;

  modport master (
    output ram_addr,
    input  ram_data,
    output r1, g1, b1, r2, g2, b2,
    output hub_clk, hub_lat, hub_oe_n, row_addr
  );

  modport slave (
    input  ram_addr,
    output ram_data,
    input  r1, g1, b1, r2, g2, b2,
    input  hub_clk, hub_lat, hub_oe_n, row_addr
  );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// HUB75 scan sequencer: prefetches pixel bytes from the framebuffer, shifts and latches each scan
// row, enables it for a fixed on-time, and swaps display banks only at frame boundaries.
module matrix_scan_ctrl #(
  parameter int unsigned COLS        = 64,
  parameter int unsigned SCAN_ROWS   = 16,
  parameter int unsigned ON_CYCLES   = 256,
  parameter int unsigned BANK_STRIDE = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               swap_req,
  output logic               swap_ack,
  output logic               bank,
  output logic               frame_start,
  matrix_scan_ctrl_if.master hub
);

  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(COLS - 1);
  localparam logic [3:0]      RowLast = 4'(SCAN_ROWS - 1);
  localparam logic [15:0]     OnLast  = 16'(ON_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StPrime0, StPrime1, StShiftL, StShiftH, StLatch, StDisplay
  } state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [3:0]      row_q, row_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            bank_q, bank_d;
  logic            pend_q, pend_d;
  logic            ack_q, ack_d;
  logic [15:0]     addr_q, addr_d;
  logic [5:0]      color_q, color_d;
  logic [3:0]      row_addr_q, row_addr_d;
  logic            unused_data;

  // Read-ahead past the last column just re-reads it.
  function automatic logic [15:0] addr_of(logic b, logic [3:0] r, int unsigned c);
    int unsigned a;
    a = (b ? BANK_STRIDE : 32'd0) + {28'd0, r} * COLS + ((c >= COLS - 1) ? COLS - 1 : c);
    return a[15:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    bank_d     = bank_q;
    pend_d     = pend_q | swap_req;
    ack_d      = 1'b0;
    addr_d     = addr_q;
    color_d    = color_q;
    row_addr_d = row_addr_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StPrime0;
          row_d   = 4'd0;
          addr_d  = addr_of(bank_q, 4'd0, 32'd0);
        end
      end
      StPrime0: state_d = StPrime1;
      StPrime1: begin
        color_d = hub.ram_data[5:0];
        col_d   = '0;
        addr_d  = addr_of(bank_q, row_q, 32'd1);
        state_d = StShiftL;
      end
      StShiftL: state_d = StShiftH;
      StShiftH: begin
        color_d = hub.ram_data[5:0];
        if (col_q == ColLast) begin
          state_d = StLatch;
        end else begin
          col_d   = col_q + ColW'(1);
          addr_d  = addr_of(bank_q, row_q, 32'(col_q) + 32'd2);
          state_d = StShiftL;
        end
      end
      StLatch: begin
        row_addr_d = row_q;
        cnt_d      = '0;
        state_d    = StDisplay;
      end
      StDisplay: begin
        if (cnt_q != OnLast) begin
          cnt_d = cnt_q + 16'd1;
        end else if (row_q != RowLast && enable) begin
          row_d   = row_q + 4'd1;
          addr_d  = addr_of(bank_q, row_q + 4'd1, 32'd0);
          state_d = StPrime0;
        end else begin
          row_d = 4'd0;
          // Only a completed frame is a swap point; an early stop keeps the request pending.
          if (row_q == RowLast && pend_d) begin
            bank_d = ~bank_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
          end
          if (enable) begin
            state_d = StPrime0;
            addr_d  = addr_of(bank_d, 4'd0, 32'd0);
          end else begin
            state_d    = StIdle;
            addr_d     = '0;
            color_d    = '0;
            row_addr_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      bank_q     <= 1'b0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      addr_q     <= '0;
      color_q    <= '0;
      row_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      addr_q     <= addr_d;
      color_q    <= color_d;
      row_addr_q <= row_addr_d;
    end
  end

  assign unused_data  = ^hub.ram_data[7:6];
  assign hub.ram_addr = addr_q;
  assign hub.r1       = color_q[0];
  assign hub.g1       = color_q[1];
  assign hub.b1       = color_q[2];
  assign hub.r2       = color_q[3];
  assign hub.g2       = color_q[4];
  assign hub.b2       = color_q[5];
  assign hub.hub_clk  = (state_q == StShiftH);
  assign hub.hub_lat  = (state_q == StLatch);
  assign hub.hub_oe_n = (state_q != StDisplay);
  assign hub.row_addr = row_addr_q;
  assign frame_start  = (state_q == StPrime0) && (row_q == 4'd0);
  assign swap_ack     = ack_q;
  assign bank         = bank_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl: stimulus queues expected rows/frames/acks, monitors
// pop and compare as the panel outputs appear. A second small instance checks exact addressing.
`timescale 1ns/1ps
module tb_matrix_scan_ctrl;
  localparam int T = 387;
  localparam int F = 6192;

  typedef struct {int row; int bnk;} row_t;
  typedef struct {int cyc; int val;} ev_t;
  typedef struct {int addr; int ctl;} sm_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic swap_req = 1'b0;
  logic s_enable = 1'b0;
  logic swap_ack, bank, frame_start;
  logic s_swap_ack, s_bank, s_frame_start;

  matrix_scan_ctrl_if hub_if ();
  matrix_scan_ctrl_if s_if ();

  matrix_scan_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .swap_req(swap_req), .swap_ack(swap_ack),
    .bank(bank), .frame_start(frame_start), .hub(hub_if)
  );

  matrix_scan_ctrl #(.COLS(4), .SCAN_ROWS(2), .ON_CYCLES(1), .BANK_STRIDE(8)) dut_s (
    .clk(clk), .rst(rst), .enable(s_enable), .swap_req(1'b0), .swap_ack(s_swap_ack),
    .bank(s_bank), .frame_start(s_frame_start), .hub(s_if)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [65536];
  always @(posedge clk) hub_if.ram_data <= mem[hub_if.ram_addr];
  always @(posedge clk) s_if.ram_data <= s_if.ram_addr[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  row_t exp_rows[$];
  ev_t  exp_frames[$];
  ev_t  exp_acks[$];
  sm_t  exp_small[$];

  int s_addr_tab [25] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3,
                          4, 4, 5, 5, 6, 6, 7, 7, 7, 7, 7, 7, 0};
  int s_ctl_tab  [25] = '{4, 0, 0, 1, 0, 1, 0, 1, 0, 1, 2, 3,
                          0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 2, 3, 4};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int colour();
    return int'({hub_if.b2, hub_if.g2, hub_if.r2, hub_if.b1, hub_if.g1, hub_if.r1});
  endfunction

  function automatic int exp_pix(int bnk, int row, int k);
    return (bnk == 0) ? k : (k + 5 * row) % 64;
  endfunction

  // Main monitor
  row_t cur = '{row: 0, bnk: 0};
  ev_t  ev;
  int   rise_cnt = 0, oe_run = 0, lat_run = 0;
  logic prev_hclk = 1'b0, prev_oe = 1'b1, prev_bank = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      rise_cnt = 0; oe_run = 0; lat_run = 0;
      prev_hclk = 1'b0; prev_oe = 1'b1; prev_bank = 1'b0;
    end else begin
      if (hub_if.hub_clk && !prev_hclk) begin
        if (rise_cnt == 0) begin
          if (exp_rows.size() == 0) chk("row_unexpected", 1, 0);
          else cur = exp_rows.pop_front();
        end
        chk("pixel", colour(), exp_pix(cur.bnk, cur.row, rise_cnt));
        rise_cnt++;
      end
      if (hub_if.hub_lat) begin
        lat_run++;
        if (lat_run == 1) chk("clks_per_row", rise_cnt, 64);
        rise_cnt = 0;
      end else if (lat_run != 0) begin
        chk("lat_width", lat_run, 1);
        lat_run = 0;
      end
      if (!hub_if.hub_oe_n) begin
        oe_run++;
        chk("oe_quiet", int'({hub_if.hub_clk, hub_if.hub_lat}), 0);
        chk("row_addr", int'(hub_if.row_addr), cur.row);
      end else if (!prev_oe) begin
        chk("oe_len", oe_run, 256);
        oe_run = 0;
      end
      if (frame_start) begin
        if (exp_frames.size() == 0) chk("frame_unexpected", 1, 0);
        else begin
          ev = exp_frames.pop_front();
          chk("frame_cycle", cyc, ev.cyc);
          chk("frame_addr", int'(hub_if.ram_addr), ev.val);
        end
      end
      if (swap_ack) begin
        if (exp_acks.size() == 0) chk("ack_unexpected", 1, 0);
        else begin
          ev = exp_acks.pop_front();
          chk("ack_cycle", cyc, ev.cyc);
          chk("ack_bank", int'(bank), ev.val);
        end
      end
      if (bank != prev_bank) chk("bank_change_acked", int'(swap_ack), 1);
      prev_hclk = hub_if.hub_clk;
      prev_oe   = hub_if.hub_oe_n;
      prev_bank = bank;
    end
  end

  // Small-instance monitor: cycle-exact address/control table from its first frame_start
  bit  s_started = 1'b0;
  sm_t sm;
  int  s_ctl;
  always @(negedge clk) begin
    if (!rst) begin
      if (s_frame_start) s_started = 1'b1;
      if (s_started && exp_small.size() > 0) begin
        sm = exp_small.pop_front();
        s_ctl = s_frame_start ? 4 : s_if.hub_clk ? 1 : s_if.hub_lat ? 2 : !s_if.hub_oe_n ? 3 : 0;
        chk("small_addr", int'(s_if.ram_addr), sm.addr);
        chk("small_ctl", s_ctl, sm.ctl);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(posedge clk);
    #1;
    swap_req = 1'b0;
  endtask

  task automatic push_rows(input int bnk, input int first, input int last);
    for (int r = first; r <= last; r++) exp_rows.push_back('{row: r, bnk: bnk});
  endtask

  task automatic chk_quiet(input string name, input int exp_bank);
    chk({name, "_oe_n"}, int'(hub_if.hub_oe_n), 1);
    chk({name, "_hclk_lat"}, int'({hub_if.hub_clk, hub_if.hub_lat}), 0);
    chk({name, "_ram_addr"}, int'(hub_if.ram_addr), 0);
    chk({name, "_row_addr"}, int'(hub_if.row_addr), 0);
    chk({name, "_colour"}, colour(), 0);
    chk({name, "_pulses"}, int'({frame_start, swap_ack}), 0);
    chk({name, "_bank"}, int'(bank), exp_bank);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int f1, r0, f4, f5;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int rr = 0; rr < 16; rr++) begin
      for (int c = 0; c < 64; c++) begin
        mem[rr * 64 + c]        = {2'(rr), 6'(c)};
        mem[4096 + rr * 64 + c] = {2'b11, 6'((c + 5 * rr) % 64)};
      end
    end

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_quiet("reset", 0);

    // Frame 1 bank 0, frame 2 bank 1 after a mid-frame swap, frame 3 stopped after row 3
    f1 = cyc + 1;
    push_rows(0, 0, 15);
    push_rows(1, 0, 15);
    push_rows(1, 0, 3);
    exp_frames.push_back('{cyc: f1, val: 0});
    exp_frames.push_back('{cyc: f1 + F, val: 4096});
    exp_frames.push_back('{cyc: f1 + 2 * F, val: 4096});
    exp_acks.push_back('{cyc: f1 + F, val: 1});
    for (int i = 0; i < 25; i++) exp_small.push_back('{addr: s_addr_tab[i], ctl: s_ctl_tab[i]});
    enable   = 1'b1;
    s_enable = 1'b1;

    wait_until(f1 + 5 * T + 20);
    pulse_swap();
    wait_until(f1 + 9 * T + 40);
    pulse_swap();
    wait_until(f1 + F - 2);
    chk("bank_before_boundary", int'(bank), 0);
    wait_until(f1 + 2 * F + 3 * T + 50);
    enable = 1'b0;
    wait_until(f1 + 2 * F + 4 * T + 3);
    chk_quiet("idle_after_drop", 1);

    // Frame 4: re-enable, request a swap, then reset mid-DISPLAY of row 2
    r0 = f1 + 2 * F + 4 * T + 10;
    wait_until(r0);
    f4 = r0 + 1;
    exp_frames.push_back('{cyc: f4, val: 4096});
    push_rows(1, 0, 2);
    enable = 1'b1;
    wait_until(f4 + T + 30);
    pulse_swap();
    wait_until(f4 + 2 * T + 200);
    chk("oe_before_reset", int'(hub_if.hub_oe_n), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_quiet("reset_mid_display", 0);

    // Frame 5 must stay on bank 0: the pre-reset swap request is gone
    f5 = cyc + 1;
    exp_frames.push_back('{cyc: f5, val: 0});
    exp_frames.push_back('{cyc: f5 + F, val: 0});
    push_rows(0, 0, 15);
    push_rows(0, 0, 0);
    wait_until(f5 + F + 50);
    enable = 1'b0;
    wait_until(f5 + F + T + 5);
    chk_quiet("idle_final", 0);
    repeat (20) @(posedge clk);
    #1;

    chk("rows_left", exp_rows.size(), 0);
    chk("frames_left", exp_frames.size(), 0);
    chk("acks_left", exp_acks.size(), 0);
    chk("small_left", exp_small.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_scan_ctrl.md
# matrix_scan_ctrl

Scan sequencer for the HUB75 LED matrix path. It reads pixel bytes from the read port of the framebuffer dual-port RAM, shifts each scan row into the panel, latches it and enables the row for a fixed on-time. It also owns double-buffer bank selection, so the writer side can request a frame swap that takes effect only at a frame boundary.

## Interface
Parameters:
- COLS, 64: pixels per panel row; shift clocks per scan row.
- SCAN_ROWS, 16: scan rows per frame; row_addr width is 4.
- ON_CYCLES, 256: clk cycles hub_oe_n is held low per row; minimum 1.
- BANK_STRIDE, 4096: address offset of bank 1; requires BANK_STRIDE ≥ COLS*SCAN_ROWS.

Ports:
- clk, in, 1: single system clock; also clocks the RAM read port.
- rst, in, 1: reset, synchronous, active-high.
- enable, in, 1: run scanning.
- swap_req, in, 1: one-cycle pulse requesting a bank swap.
- swap_ack, out, 1: one-cycle pulse when the bank toggles.
- bank, out, 1: bank currently displayed.
- ram_addr, out, 16: RAM read address (registered).
- ram_data, in, 8: RAM read data; valid one cycle after ram_addr.
- r1, g1, b1, r2, g2, b2, out, 1 each: panel colour data.
- hub_clk, out, 1: panel shift clock.
- hub_lat, out, 1: panel latch strobe.
- hub_oe_n, out, 1: panel output enable, active low.
- row_addr, out, 4: panel row select.
- frame_start, out, 1: one-cycle pulse at the start of a frame.

## Operation
- Pixel byte format:
  - bits [2:0] = {b1,g1,r1} for upper row r.
  - bits [5:3] = {b2,g2,r2} for lower row r+SCAN_ROWS.
  - bits [7:6] are ignored.
- Address = bank*BANK_STRIDE + row*COLS + col, truncated mod 2^16.
- States: IDLE, PRIME0, PRIME1, SHIFT_L, SHIFT_H, LATCH, DISPLAY.
- IDLE:
  - Outputs are at reset values.
  - On enable=1, go to PRIME0 with row=0.
- PRIME0:
  - ram_addr = addr(row, 0).
  - If row==0, frame_start=1 for this cycle.
- PRIME1:
  - ram_data holds col 0.
  - Colour outputs load it at the end of the cycle; ram_addr advances to col 1.
- SHIFT_L(c):
  - hub_clk=0, colour outputs show col c.
  - ram_addr = addr(row, c+1), clamped to col COLS-1 when c = COLS-1.
- SHIFT_H(c):
  - hub_clk=1.
  - Colour outputs load ram_data (col c+1) at the end of the cycle.
  - If c < COLS-1, go to SHIFT_L(c+1); otherwise go to LATCH.
- LATCH:
  - One cycle: hub_lat=1, hub_clk=0, row_addr <= row.
- DISPLAY:
  - hub_oe_n=0 for exactly ON_CYCLES cycles; row_addr is stable throughout.
  - Exit when row < SCAN_ROWS-1: row+1 and PRIME0.
  - Exit at the last row:
    - Frame boundary, row=0.
    - If a swap is pending: bank toggles, swap_ack pulses in the first cycle of the next state, and the pending flag clears.
    - Next state is PRIME0 if enable=1, else IDLE.
- hub_oe_n=1 in every state except DISPLAY.
- Panel data never changes while the panel is enabled.
- Dropping enable mid-frame: the current row completes through DISPLAY, then the block goes to IDLE; row resets to 0.
- Re-enabling starts a new frame.
- Swap handling:
  - A swap_req pulse sets a sticky pending flag.
  - Further pulses while pending have no additional effect.
  - A swap_req coinciding with the frame-boundary cycle is honoured at that boundary.
  - bank never changes mid-frame.

## Timing
- Reset values (rst=1 → next edge):
  - state IDLE, row 0, bank 0, pending 0.
  - ram_addr 0, all colour outputs 0.
  - hub_clk 0, hub_lat 0, hub_oe_n 1, row_addr 0.
  - swap_ack 0, frame_start 0.
- rst has priority over every state, including mid-shift and mid-DISPLAY.
- Cycles per row = 2 + 2*COLS + 1 + ON_CYCLES; 387 with defaults.
- Frame = SCAN_ROWS × row period; 6192 cycles with defaults, back-to-back while enabled.
- Enable to first frame_start: one cycle (IDLE→PRIME0).
- The column counter is log2(COLS) bits wide and the DISPLAY counter is 16 bits.
- Address arithmetic is 16-bit unsigned with wrap.

## Test plan
- Reset then enable=1, RAM bank 0 filled with byte = col[5:0]:
  - frame_start at cycle 1 and again 6192 cycles later.
  - Exactly 64 hub_clk rising edges per row.
  - At rising edge k, {b2,g2,r2,b1,g1,r1} = k[5:0].
- Row timing:
  - hub_lat high exactly one cycle per row; row_addr counts 0..15 then wraps to 0.
  - hub_oe_n low for exactly 256 consecutive cycles per row.
  - hub_oe_n is never low while hub_clk toggles or hub_lat=1.
- Swap request mid-frame:
  - Pulse swap_req at row 5: bank stays 0 until the last row's DISPLAY ends.
  - Then swap_ack pulses once, bank=1, and the next PRIME0 ram_addr is 4096.
  - A second swap_req pulse during pending produces a single toggle.
- Enable dropped mid-frame:
  - Deassert enable during SHIFT of row 3: row 3 still latches and displays 256 cycles, then IDLE with hub_oe_n=1.
  - Re-enable: frame_start fires and row_addr restarts at 0.
- Reset mid-DISPLAY:
  - Assert rst for one cycle: next cycle hub_oe_n=1, bank=0, ram_addr=0, all outputs at reset values.
  - A pending swap is discarded.
- Parameters COLS=4, SCAN_ROWS=2, ON_CYCLES=1:
  - Row period is 12 cycles.
  - Addresses sequence 0,1,2,3 then 4..7.
  - Last column SHIFT_L holds ram_addr=3.
